// File: rtl/cross_bar_master_agent.sv
// rtl/cross_bar_master_agent.sv - req/ack bus master with command FIFO, ack timeout and response stream
//
// cross_bar_pkg carries the bus widths shared by every cross-bar agent.
//
// cross_bar_master_agent
//   Accepts commands on a valid/ready stream into a FIFO, issues them one at a
//   time as req/addr/cmd/wdata on the cross-bar bus, waits for a one-cycle ack
//   (or aborts after TIMEOUT cycles) and returns one response per command.
//
// Ports
//   clk, areset                     clock, asynchronous active-high reset
//   cmd_valid/ready/write/addr/wdata  command stream in
//   rsp_valid/ready/write/rdata/timeout  response stream out
//   master_req/addr/cmd/wdata       bus request out
//   master_ack/rdata                bus acknowledge and read data in
//   stray_ack                       sticky flag: ack seen with no request outstanding

package cross_bar_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
endpackage

module cross_bar_master_agent #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                             clk,
    input  logic                             areset,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic                             cmd_write,
    input  logic [cross_bar_pkg::ADDR_W-1:0] cmd_addr,
    input  logic [cross_bar_pkg::DATA_W-1:0] cmd_wdata,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic                             rsp_write,
    output logic [cross_bar_pkg::DATA_W-1:0] rsp_rdata,
    output logic                             rsp_timeout,
    output logic                             master_req,
    output logic [cross_bar_pkg::ADDR_W-1:0] master_addr,
    output logic                             master_cmd,
    output logic [cross_bar_pkg::DATA_W-1:0] master_wdata,
    input  logic                             master_ack,
    input  logic [cross_bar_pkg::DATA_W-1:0] master_rdata,
    output logic                             stray_ack
);
    localparam int ADDR_W = cross_bar_pkg::ADDR_W;
    localparam int DATA_W = cross_bar_pkg::DATA_W;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int TMR_W  = $clog2(TIMEOUT) + 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t state, state_next;

    // FIFO storage is not reset: occupancy comes only from the pointers.
    logic              fifo_write [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_addr  [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_wdata [FIFO_DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0]    wr_ptr, rd_ptr;
    logic              fifo_empty, fifo_full;
    logic              push, pop;
    logic              done_ack, done_timeout;
    logic [TMR_W-1:0]  timer;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = ((wr_ptr ^ rd_ptr) == {1'b1, {PTR_W{1'b0}}});
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && cmd_ready;

    assign master_req = (state == REQ);
    assign rsp_valid  = (state == RSP);

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        pop          = 1'b0;
        done_ack     = 1'b0;
        done_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                // Ack takes priority over a timeout landing in the same cycle.
                if (master_ack) begin
                    done_ack   = 1'b1;
                    state_next = RSP;
                end else if (timer == TMR_LAST) begin
                    done_timeout = 1'b1;
                    state_next   = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_write[wr_ptr[PTR_W-1:0]] <= cmd_write;
            fifo_addr[wr_ptr[PTR_W-1:0]]  <= cmd_addr;
            fifo_wdata[wr_ptr[PTR_W-1:0]] <= cmd_wdata;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            timer        <= '0;
            master_addr  <= '0;
            master_cmd   <= 1'b0;
            master_wdata <= '0;
            rsp_write    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_timeout  <= 1'b0;
            stray_ack    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr       <= rd_ptr + 1'b1;
                master_cmd   <= fifo_write[rd_ptr[PTR_W-1:0]];
                master_addr  <= fifo_addr[rd_ptr[PTR_W-1:0]];
                master_wdata <= fifo_wdata[rd_ptr[PTR_W-1:0]];
                timer        <= '0;
            end else if (state == REQ && !done_ack && !done_timeout) begin
                timer <= timer + 1'b1;
            end
            if (done_ack) begin
                rsp_write   <= master_cmd;
                rsp_rdata   <= master_cmd ? '0 : master_rdata;
                rsp_timeout <= 1'b0;
            end else if (done_timeout) begin
                rsp_write   <= master_cmd;
                rsp_rdata   <= '0;
                rsp_timeout <= 1'b1;
            end
            if (master_ack && !master_req) begin
                stray_ack <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cross_bar_master_agent.sv
// tb/tb_cross_bar_master_agent.sv - directed self-checking bench for cross_bar_master_agent
module tb_cross_bar_master_agent;
    logic        clk = 1'b0;
    logic        areset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_write, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        master_req, master_cmd, master_ack, stray_ack;
    logic [31:0] master_addr, master_wdata, master_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    cross_bar_master_agent #(.FIFO_DEPTH(4), .TIMEOUT(8)) dut (
        .clk(clk), .areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
        .master_req(master_req), .master_addr(master_addr), .master_cmd(master_cmd),
        .master_wdata(master_wdata), .master_ack(master_ack), .master_rdata(master_rdata),
        .stray_ack(stray_ack)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d);
        int guard = 0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        while (!cmd_ready && guard < 100) begin
            step();
            guard++;
        end
        check_eq("push_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int guard = 0;
        while (!master_req && guard < 20) begin
            step();
            guard++;
        end
        check_eq(tag, master_req, 1);
    endtask

    // Counts req-high cycles; pulses ack on cycle ack_cycle (0 = never).
    task automatic run_txn(input int ack_cycle, input logic [31:0] rd,
                           output int cycles, output logic stable);
        logic [31:0] a0, d0;
        logic        c0;
        a0 = master_addr; d0 = master_wdata; c0 = master_cmd;
        cycles = 0;
        stable = 1'b1;
        while (master_req && cycles < 200) begin
            cycles++;
            if (master_addr !== a0 || master_wdata !== d0 || master_cmd !== c0) stable = 1'b0;
            if (cycles == ack_cycle) begin
                master_ack   = 1'b1;
                master_rdata = rd;
            end
            step();
            master_ack   = 1'b0;
            master_rdata = 32'hBAD0_BAD0;
        end
    endtask

    task automatic take_rsp(input string tag, input logic w, input logic [31:0] rd, input logic to);
        check_eq({tag, "_rsp_valid"}, rsp_valid, 1);
        check_eq({tag, "_rsp_write"}, rsp_write, w);
        check_eq({tag, "_rsp_rdata"}, rsp_rdata, rd);
        check_eq({tag, "_rsp_timeout"}, rsp_timeout, to);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check_eq({tag, "_rsp_drop"}, rsp_valid, 0);
    endtask

    initial begin
        int   cyc;
        logic stab;
        logic ok;

        areset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; master_ack = 1'b0; master_rdata = 32'hBAD0_BAD0;
        step(); step();
        areset = 1'b0;

        check_eq("rst_master_req", master_req, 0);
        check_eq("rst_cmd_ready", cmd_ready, 1);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_stray_ack", stray_ack, 0);
        check_eq("rst_master_addr", master_addr, 0);
        check_eq("rst_rsp_rdata", rsp_rdata, 0);

        // 1: write, ack on 3rd req cycle
        push(1'b1, 32'h10, 32'hDEAD_BEEF);
        check_eq("t1_req_after_push", master_req, 0);
        step();
        check_eq("t1_req_next_edge", master_req, 1);
        check_eq("t1_addr", master_addr, 32'h10);
        check_eq("t1_wdata", master_wdata, 32'hDEAD_BEEF);
        check_eq("t1_cmd", master_cmd, 1);
        run_txn(3, 32'h0, cyc, stab);
        check_eq("t1_req_cycles", cyc, 3);
        check_eq("t1_stable", stab, 1);
        take_rsp("t1", 1'b1, 32'h0, 1'b0);

        // 2: read, ack on 1st cycle
        push(1'b0, 32'h20, 32'h0);
        check_eq("t2_req_after_push", master_req, 0);
        step();
        check_eq("t2_req_next_edge", master_req, 1);
        check_eq("t2_cmd", master_cmd, 0);
        run_txn(1, 32'h1234_5678, cyc, stab);
        check_eq("t2_req_cycles", cyc, 1);
        take_rsp("t2", 1'b0, 32'h1234_5678, 1'b0);

        // 3: five commands, FIFO fills while the first is outstanding
        push(1'b0, 32'h100, 32'hD00);
        wait_req("t3_req0");
        for (int k = 1; k < 5; k++) push(k[0], 32'h100 + k, 32'hD00 + k);
        check_eq("t3_full", cmd_ready, 0);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                check_eq("t3_gap", master_req, 0);
                wait_req("t3_req");
            end
            if (k == 1) check_eq("t3_ready_after_pop", cmd_ready, 1);
            check_eq("t3_order_addr", master_addr, 32'h100 + k);
            check_eq("t3_order_cmd", master_cmd, k[0]);
            run_txn(2, 32'hA000 + k, cyc, stab);
            check_eq("t3_req_cycles", cyc, 2);
            take_rsp("t3", k[0], k[0] ? 32'h0 : 32'hA000 + k, 1'b0);
        end

        // 4: timeout, then ack on the last allowed cycle
        push(1'b0, 32'h30, 32'h0);
        wait_req("t4_req_a");
        run_txn(0, 32'h0, cyc, stab);
        check_eq("t4_timeout_cycles", cyc, 8);
        take_rsp("t4a", 1'b0, 32'h0, 1'b1);
        push(1'b0, 32'h34, 32'h0);
        wait_req("t4_req_b");
        run_txn(8, 32'h55AA, cyc, stab);
        check_eq("t4_ack8_cycles", cyc, 8);
        take_rsp("t4b", 1'b0, 32'h55AA, 1'b0);

        // 5: response back-pressure, then stray ack in IDLE
        push(1'b1, 32'h40, 32'h4444);
        wait_req("t5_req");
        run_txn(1, 32'h0, cyc, stab);
        push(1'b0, 32'h44, 32'h0);
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!rsp_valid || !rsp_write || rsp_rdata !== 32'h0 || rsp_timeout || master_req) ok = 1'b0;
            step();
        end
        check_eq("t5_rsp_hold", ok, 1);
        take_rsp("t5a", 1'b1, 32'h0, 1'b0);
        wait_req("t5_req_b");
        check_eq("t5_addr_b", master_addr, 32'h44);
        run_txn(1, 32'h4321, cyc, stab);
        take_rsp("t5b", 1'b0, 32'h4321, 1'b0);
        check_eq("t5_stray_clear", stray_ack, 0);
        master_ack = 1'b1;
        step();
        master_ack = 1'b0;
        check_eq("t5_stray_set", stray_ack, 1);
        check_eq("t5_stray_no_rsp", rsp_valid, 0);
        step(); step(); step();
        check_eq("t5_stray_sticky", stray_ack, 1);

        // 6: reset mid-transaction with two queued commands
        push(1'b0, 32'h50, 32'h0);
        wait_req("t6_req");
        push(1'b1, 32'h54, 32'h1);
        push(1'b0, 32'h58, 32'h2);
        check_eq("t6_req_before", master_req, 1);
        areset = 1'b1;
        #1;
        check_eq("t6_req_drop", master_req, 0);
        check_eq("t6_cmd_ready", cmd_ready, 1);
        check_eq("t6_rsp_valid", rsp_valid, 0);
        check_eq("t6_stray_cleared", stray_ack, 0);
        step(); step();
        areset = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (master_req || rsp_valid) ok = 1'b0;
            step();
        end
        check_eq("t6_flushed", ok, 1);
        check_eq("t6_ready_after", cmd_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
